// File: rtl/ship_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ship_lane_ctrl
// Purpose  : Player-ship lane tracker with edge-detected buttons and a
//            valid/ready shot request gated by a programmable cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module ship_lane_ctrl #(
    parameter int LANES    = 3,
    parameter int IDXW     = 2,
    parameter int START    = 1,
    parameter int WRAP     = 0,
    parameter int COOLDOWN = 4,
    parameter int CW       = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LEFT,
    input  logic             RIGHT,
    input  logic             FIRE,
    input  logic             SHOT_RDY,
    output logic [LANES-1:0] POS,
    output logic [IDXW-1:0]  IDX,
    output logic             SHOT_VLD,
    output logic [IDXW-1:0]  SHOT_LANE,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(LANES - 1);
    localparam logic [IDXW-1:0] START_IDX = IDXW'(START);
    localparam logic [IDXW-1:0] ONE_IDX   = IDXW'(1);
    localparam logic [CW-1:0]   ONE_CNT   = CW'(1);
    localparam logic [CW-1:0]   COOL_LOAD = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;
    localparam logic [LANES-1:0] POS_ONE  = LANES'(1);

    logic            left_q, right_q, fire_q;
    logic            rise_l, rise_r, rise_f;
    logic [IDXW-1:0] idx_q, idx_d;
    state_t          state_q, state_d;
    logic [IDXW-1:0] shot_lane_q, shot_lane_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            shot_vld_q, shot_vld_d;
    logic            busy_q, busy_d;

    // Edge registers track the buttons every cycle so a press held across
    // EN rising is never seen as a new edge.
    assign rise_l = LEFT  & ~left_q;
    assign rise_r = RIGHT & ~right_q;
    assign rise_f = FIRE  & ~fire_q;

    always_comb begin
        idx_d = idx_q;
        if (EN && rise_l && !rise_r) begin
            if (idx_q == '0) begin
                idx_d = (WRAP != 0) ? LAST_IDX : '0;
            end else begin
                idx_d = idx_q - ONE_IDX;
            end
        end else if (EN && rise_r && !rise_l) begin
            if (idx_q >= LAST_IDX) begin
                idx_d = (WRAP != 0) ? '0 : LAST_IDX;
            end else begin
                idx_d = idx_q + ONE_IDX;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shot_lane_d = shot_lane_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (EN && rise_f) begin
                    state_d     = ST_PEND;
                    shot_lane_d = idx_q;
                end
            end
            ST_PEND: begin
                if (SHOT_RDY) begin
                    if (COOLDOWN == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COOL;
                        cnt_d   = COOL_LOAD;
                    end
                end
            end
            ST_COOL: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE_CNT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        shot_vld_d = (state_d == ST_PEND);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            fire_q      <= 1'b0;
            idx_q       <= START_IDX;
            state_q     <= ST_IDLE;
            shot_lane_q <= '0;
            cnt_q       <= '0;
            shot_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            left_q      <= LEFT;
            right_q     <= RIGHT;
            fire_q      <= FIRE;
            idx_q       <= idx_d;
            state_q     <= state_d;
            shot_lane_q <= shot_lane_d;
            cnt_q       <= cnt_d;
            shot_vld_q  <= shot_vld_d;
            busy_q      <= busy_d;
        end
    end

    assign IDX       = idx_q;
    assign POS       = POS_ONE << idx_q;
    assign SHOT_VLD  = shot_vld_q;
    assign SHOT_LANE = shot_lane_q;
    assign BUSY      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ship_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ship_lane_ctrl
// Purpose  : Directed scoreboard bench for ship_lane_ctrl in three configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ship_lane_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic EN  = 1'b0;

    // Instance A: defaults
    logic       a_l = 0, a_r = 0, a_f = 0, a_rdy = 0;
    logic [2:0] a_pos;
    logic [1:0] a_idx, a_lane;
    logic       a_vld, a_busy;

    // Instance B: 5 lanes, wrapping, start at 0
    logic       b_l = 0, b_r = 0, b_f = 0, b_rdy = 0;
    logic [4:0] b_pos;
    logic [2:0] b_idx, b_lane;
    logic       b_vld, b_busy;

    // Instance C: no cooldown, consumer always ready
    logic       c_l = 0, c_r = 0, c_f = 0, c_rdy = 1;
    logic [2:0] c_pos;
    logic [1:0] c_idx, c_lane;
    logic       c_vld, c_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_a   = 0;
    int hs_c   = 0;
    logic [1:0] exp_a[$];
    logic [1:0] exp_c[$];

    always #5 CLK = ~CLK;

    ship_lane_ctrl u_a (
        .CLK(CLK), .RST(RST), .EN(EN), .LEFT(a_l), .RIGHT(a_r), .FIRE(a_f),
        .SHOT_RDY(a_rdy), .POS(a_pos), .IDX(a_idx), .SHOT_VLD(a_vld),
        .SHOT_LANE(a_lane), .BUSY(a_busy)
    );

    ship_lane_ctrl #(.LANES(5), .IDXW(3), .START(0), .WRAP(1), .COOLDOWN(4), .CW(3)) u_b (
        .CLK(CLK), .RST(RST), .EN(EN), .LEFT(b_l), .RIGHT(b_r), .FIRE(b_f),
        .SHOT_RDY(b_rdy), .POS(b_pos), .IDX(b_idx), .SHOT_VLD(b_vld),
        .SHOT_LANE(b_lane), .BUSY(b_busy)
    );

    ship_lane_ctrl #(.COOLDOWN(0)) u_c (
        .CLK(CLK), .RST(RST), .EN(EN), .LEFT(c_l), .RIGHT(c_r), .FIRE(c_f),
        .SHOT_RDY(c_rdy), .POS(c_pos), .IDX(c_idx), .SHOT_VLD(c_vld),
        .SHOT_LANE(c_lane), .BUSY(c_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Scoreboard monitors: every accepted shot must match the next queued lane
    always @(negedge CLK) begin
        if (!RST && a_vld && a_rdy) begin
            hs_a++;
            if (exp_a.size() == 0) chk("a_unexpected_shot", 32'(a_lane), 32'hdead);
            else chk("a_shot_lane", 32'(a_lane), 32'(exp_a.pop_front()));
        end
        if (!RST && c_vld && c_rdy) begin
            hs_c++;
            if (exp_c.size() == 0) chk("c_unexpected_shot", 32'(c_lane), 32'hdead);
            else chk("c_shot_lane", 32'(c_lane), 32'(exp_c.pop_front()));
        end
        if (!RST && b_vld) chk("b_no_shot", 32'(b_vld), 32'd0);
    end

    initial begin
        tick(3);
        RST = 1'b0;
        tick();
        // Reset state
        chk("a_rst_idx", 32'(a_idx), 32'd1);
        chk("a_rst_pos", 32'(a_pos), 32'b010);
        chk("a_rst_vld", 32'(a_vld), 32'd0);
        chk("a_rst_busy", 32'(a_busy), 32'd0);
        chk("a_rst_lane", 32'(a_lane), 32'd0);
        chk("b_rst_idx", 32'(b_idx), 32'd0);
        chk("b_rst_pos", 32'(b_pos), 32'b00001);
        EN = 1'b1;
        tick();

        // Saturating moves
        a_r = 1; tick(); a_r = 0;
        chk("a_r1_idx", 32'(a_idx), 32'd2);
        chk("a_r1_pos", 32'(a_pos), 32'b100);
        tick();
        a_r = 1; tick(); a_r = 0; tick();
        chk("a_sat_right", 32'(a_idx), 32'd2);
        a_l = 1; tick(); a_l = 0; tick();
        chk("a_l1_idx", 32'(a_idx), 32'd1);
        a_l = 1; tick(); a_l = 0; tick();
        chk("a_l2_idx", 32'(a_idx), 32'd0);
        chk("a_l2_pos", 32'(a_pos), 32'b001);
        a_l = 1; tick(); a_l = 0; tick();
        chk("a_sat_left", 32'(a_idx), 32'd0);

        // Wrapping and hold-gives-one-move
        b_l = 1; tick(); b_l = 0;
        chk("b_wrap_left", 32'(b_idx), 32'd4);
        chk("b_wrap_pos", 32'(b_pos), 32'b10000);
        tick();
        b_r = 1; tick(); b_r = 0; tick();
        chk("b_wrap_right", 32'(b_idx), 32'd0);
        b_r = 1; tick(10);
        chk("b_hold_idx", 32'(b_idx), 32'd1);
        chk("b_hold_pos", 32'(b_pos), 32'b00010);
        b_r = 0; tick();

        // Simultaneous rise and held button
        a_r = 1; tick(); a_r = 0; tick();
        chk("a_to1", 32'(a_idx), 32'd1);
        a_l = 1; a_r = 1; tick();
        chk("a_both_rise", 32'(a_idx), 32'd1);
        a_r = 0; tick();
        chk("a_hold_left", 32'(a_idx), 32'd1);
        a_r = 1; tick();
        chk("a_right_under_left", 32'(a_idx), 32'd2);
        a_l = 0; a_r = 0; tick();

        // Fire handshake with cooldown
        exp_a.push_back(2'd2);
        a_f = 1; tick(); a_f = 0;
        chk("a_pend_vld", 32'(a_vld), 32'd1);
        chk("a_pend_busy", 32'(a_busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a_l = (i == 1);
            tick();
            chk("a_pend_hold_vld", 32'(a_vld), 32'd1);
            chk("a_pend_hold_lane", 32'(a_lane), 32'd2);
        end
        a_l = 0;
        chk("a_move_in_pend", 32'(a_idx), 32'd1);
        a_rdy = 1; tick(); a_rdy = 0;
        chk("a_post_hs_vld", 32'(a_vld), 32'd0);
        chk("a_cool_busy0", 32'(a_busy), 32'd1);
        a_f = 1; tick(); a_f = 0;
        chk("a_cool_busy1", 32'(a_busy), 32'd1);
        tick();
        chk("a_cool_busy2", 32'(a_busy), 32'd1);
        tick();
        chk("a_cool_busy3", 32'(a_busy), 32'd1);
        chk("a_cool_vld", 32'(a_vld), 32'd0);
        tick();
        chk("a_cool_done", 32'(a_busy), 32'd0);
        chk("a_fire_in_cool_ignored", 32'(a_vld), 32'd0);
        tick(2);
        chk("a_still_idle", 32'(a_vld), 32'd0);

        // Zero cooldown, always-ready consumer
        exp_c.push_back(2'd1);
        exp_c.push_back(2'd1);
        c_f = 1; tick(); c_f = 0;
        chk("c_p1_vld", 32'(c_vld), 32'd1);
        chk("c_p1_busy", 32'(c_busy), 32'd1);
        tick();
        chk("c_p1_end", 32'(c_vld), 32'd0);
        chk("c_p1_idle", 32'(c_busy), 32'd0);
        c_f = 1; tick(); c_f = 0;
        chk("c_p2_vld", 32'(c_vld), 32'd1);
        tick();
        chk("c_p2_end", 32'(c_vld), 32'd0);
        tick();

        // Async reset while a shot is pending
        a_l = 1; tick(); a_l = 0; tick();
        chk("a_pre_rst_idx", 32'(a_idx), 32'd0);
        a_f = 1; tick();
        chk("a_pre_rst_vld", 32'(a_vld), 32'd1);
        chk("a_pre_rst_lane", 32'(a_lane), 32'd0);
        #3;
        RST = 1'b1; EN = 1'b0;
        #1;
        chk("a_async_vld", 32'(a_vld), 32'd0);
        chk("a_async_busy", 32'(a_busy), 32'd0);
        chk("a_async_idx", 32'(a_idx), 32'd1);
        chk("a_async_pos", 32'(a_pos), 32'b010);
        tick(2);
        RST = 1'b0;
        tick(2);
        EN = 1'b1;
        tick(3);
        chk("a_held_fire_no_shot", 32'(a_vld), 32'd0);
        chk("a_held_fire_idle", 32'(a_busy), 32'd0);
        a_f = 0; tick();
        exp_a.push_back(2'd1);
        a_f = 1; tick(); a_f = 0;
        chk("a_repress_vld", 32'(a_vld), 32'd1);
        chk("a_repress_lane", 32'(a_lane), 32'd1);
        a_rdy = 1; tick(); a_rdy = 0;
        chk("a_repress_done", 32'(a_vld), 32'd0);
        tick(5);
        chk("a_final_idle", 32'(a_busy), 32'd0);

        chk("a_handshakes", 32'(hs_a), 32'd2);
        chk("c_handshakes", 32'(hs_c), 32'd2);
        chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
        chk("c_queue_empty", 32'(exp_c.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
